number_feeder: RTL and testbench
================================

NUMBER_FEEDER -- requirements
Module: number_feeder

Interface
REQ-001 Parameter WIDTH, default 6, sets the bit width of each stored number.
REQ-002 Parameter DEPTH, default 16, sets the number of memory entries.
REQ-003 Parameter ADDR_W, default 4, sets the address and count width; it SHALL satisfy 2^ADDR_W = DEPTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low; rst=0 at a rising edge resets the block.
REQ-006 wr_en  input  1  memory write strobe.
REQ-007 wr_addr  input  ADDR_W  memory write address.
REQ-008 wr_data  input  WIDTH  memory write data.
REQ-009 cnt  input  ADDR_W  number of entries to stream; 0 means DEPTH.
REQ-010 start  input  1  single-cycle stream request.
REQ-011 busy  output  1  high in STREAM and FINISH.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  downstream (max finder) accepts out_data.
REQ-014 out_data  output  WIDTH  current number.
REQ-015 out_last  output  1  marks the final number of the stream.
REQ-016 done  output  1  one-cycle pulse after the last transfer.

Function
REQ-017 The FSM SHALL have three states: IDLE, STREAM and FINISH.
REQ-018 In IDLE with wr_en=1, mem[wr_addr] SHALL take wr_data at the edge.
REQ-019 In STREAM or FINISH, wr_en SHALL be ignored and memory SHALL be unchanged.
REQ-020 In IDLE with start=1, the block SHALL set ptr=0, latch len = (cnt==0 ? DEPTH : cnt), and go to STREAM.
REQ-021 Start latency SHALL be one cycle: out_valid is high in the first cycle after the start edge.
REQ-022 If start=1 and wr_en=1 in the same IDLE cycle, the write SHALL occur and streaming SHALL begin, and the new value SHALL be visible in the stream.
REQ-023 start SHALL be ignored in STREAM and FINISH.
REQ-024 In STREAM, out_valid SHALL be 1, out_data SHALL equal mem[ptr] (combinational read from registered ptr), and out_last SHALL equal (ptr == len-1).
REQ-025 A transfer SHALL occur on an edge where out_valid=1 and out_ready=1; on a transfer, ptr SHALL increment by 1.
REQ-026 On a transfer with out_last=1, the FSM SHALL go to FINISH and ptr SHALL NOT wrap or increment past len-1.
REQ-027 While out_ready=0, out_data, out_last and ptr SHALL hold stable; there is no timeout.
REQ-028 ptr and len SHALL be ADDR_W+1 bits wide so that len=DEPTH is represented without overflow.
REQ-029 In FINISH, done=1 and out_valid=0 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-030 out_valid, out_last and done SHALL be 0 in IDLE.
REQ-031 out_data SHALL be 0 whenever out_valid=0.
REQ-032 busy SHALL be 1 exactly in STREAM and FINISH.
REQ-033 Total cycles from the start edge to the done pulse SHALL be len + 1 when out_ready is held at 1.

Reset
REQ-034 rst=0 at an edge SHALL force IDLE, ptr=0, len=0, busy=0, out_valid=0, out_last=0, out_data=0, done=0, and all memory entries to 0.
REQ-035 Reset SHALL take priority over start, wr_en and transfers in the same cycle.
REQ-036 Reset mid-stream SHALL abort the stream with no done pulse.
REQ-037 Inputs SHALL be ignored while rst=0.

Verification
REQ-038 Load mem[i]=i+3 for i=0..15, cnt=0, start, out_ready=1 -> 16 transfers of 3..18, out_last on 18, done 17 cycles after the start edge.
REQ-039 cnt=5, data {7,63,0,12,9}, out_ready=1 -> 5 transfers, out_last with 9, done pulse, busy low the next cycle.
REQ-040 Stream with out_ready toggled 1,0,0,1,... -> out_data held during stalls; no value lost or duplicated; order preserved.
REQ-041 wr_en=1 to addr 0 with data 42 during STREAM -> mem[0] unchanged; a subsequent stream emits the old value; start pulsed during the stream -> no restart.
REQ-042 rst=0 at the 3rd transfer of a 16-entry stream -> next cycle all outputs 0, done never pulses; a stream after reset emits all zeros.
REQ-043 Same-cycle start plus write to addr 0 with data 55 -> first streamed value 55.

Source files
------------

// File: rtl/number_feeder_if.sv
// Bundle of the memory-load and stream signals shared between the number
// feeder and its controller or downstream consumer. The master modport is the
// controller side. The slave modport is the feeder itself.
`timescale 1ns/1ps
interface number_feeder_if #(
  parameter int WIDTH  = 6,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] cnt;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, cnt, start, out_ready,
    input  busy, out_valid, out_data, out_last, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cnt, start, out_ready,
    output busy, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/number_feeder.sv
// Number feeder: a small register-file memory that is loaded while idle.
// On request it streams the first len entries out through a valid/ready port.
// A one-cycle done pulse follows the final transfer.
`timescale 1ns/1ps
module number_feeder #(
  parameter int WIDTH  = 6,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4   // must satisfy 2**ADDR_W == DEPTH
) (
  input  logic            clk,
  input  logic            rst,   // synchronous, active-low
  number_feeder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // One extra bit so that a full-depth stream (len == DEPTH) fits.
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              streaming;
  logic              is_last;
  logic              mem_we;

  assign streaming = (state_q == S_STREAM);
  // len is never zero while streaming, so len-1 cannot underflow there.
  assign is_last   = (ptr_q == len_q - ONE);
  // The memory is frozen while a stream is in flight.
  assign mem_we    = bus.wr_en && (state_q == S_IDLE);

  // Next-state logic: start, advance the pointer on each transfer, and finish after the last one.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ptr_d   = '0;
          len_d   = (bus.cnt == '0) ? LEN_FULL : {1'b0, bus.cnt};
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.out_ready) begin
          // The pointer parks on the last entry rather than stepping past len-1.
          if (is_last) state_d = S_FINISH;
          else         ptr_d   = ptr_q + ONE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state registers. A low rst clears them, ahead of any start or transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so that every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end

  // Number storage. It is written only while idle and is cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: memories are usually left unreset so they can map to RAM macros.
    // This one is a small flop array that must read back as zeros after reset,
    // so every entry is cleared here.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Stream outputs are decoded from the registered state. Data is forced to zero when not valid.
  assign bus.out_valid = streaming;
  assign bus.out_data  = streaming ? mem_q[ptr_q[ADDR_W-1:0]] : '0;
  assign bus.out_last  = streaming && is_last;
  assign bus.done      = (state_q == S_FINISH);
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_number_feeder.sv
// Scoreboard bench for number_feeder. Stimulus pushes the expected stream into
// a queue. A negedge monitor pops one entry per accepted transfer and checks it.
`timescale 1ns/1ps
module tb_number_feeder;

  typedef struct {
    logic [5:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  logic       stall_prev = 1'b0;
  logic [5:0] held_data  = '0;
  logic       held_last  = 1'b0;

  number_feeder_if #(.WIDTH(6), .ADDR_W(4)) ifc ();

  number_feeder #(.WIDTH(6), .DEPTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int data, input bit last);
    exp_t e;
    e.data = 6'(data);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic write_mem(input int addr, input int data);
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = 4'(addr);
    ifc.wr_data = 6'(data);
    tick();
    ifc.wr_en   = 1'b0;
  endtask

  function automatic logic ready_for(input int pattern, input int k);
    if (pattern == 1) return ((k % 3) == 0);  // 1,0,0,1,0,0,...
    return 1'b1;
  endfunction

  // Run one stream.
  // - pattern: the out_ready sequence to apply.
  // - mode 1:  issue a write to addr 0 and a start in the second stream cycle.
  // - do_wr:   issue a write in the start cycle itself.
  task automatic run_stream(input int c, input int len, input int pattern,
                            input int mode, input bit do_wr,
                            input int waddr, input int wdata);
    int k;
    ifc.cnt   = 4'(c);
    ifc.start = 1'b1;
    if (do_wr) begin
      ifc.wr_en   = 1'b1;
      ifc.wr_addr = 4'(waddr);
      ifc.wr_data = 6'(wdata);
    end
    ifc.out_ready = ready_for(pattern, 0);
    tick();
    ifc.start = 1'b0;
    ifc.wr_en = 1'b0;
    k = 0;
    while (!ifc.done && k < 200) begin
      if (mode == 1 && k == 1) begin
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = 4'd0;
        ifc.wr_data = 6'd42;
        ifc.start   = 1'b1;
      end
      tick();
      k++;
      ifc.wr_en     = 1'b0;
      ifc.start     = 1'b0;
      ifc.out_ready = ready_for(pattern, k);
    end
    if (!ifc.done) begin
      check("done_timeout", k, -1);
    end else begin
      // With out_ready held high, done is seen len edges after the start edge.
      // The pulse therefore spans the cycle ending len+1 edges after start.
      if (pattern == 0) check("done_latency", k, len);
      check("finish_busy", int'(ifc.busy), 1);
      check("finish_valid", int'(ifc.out_valid), 0);
      tick();
      check("done_one_cycle", int'(ifc.done), 0);
      check("busy_after_done", int'(ifc.busy), 0);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    ifc.out_ready = 1'b1;
  endtask

  // Monitor: on each transfer, pop the scoreboard and compare.
  // It also checks that data is held during stalls and is zero when not valid.
  always @(negedge clk) begin
    if (rst) begin
      if (!ifc.out_valid) check("data_zero_when_invalid", int'(ifc.out_data), 0);
      if (stall_prev && ifc.out_valid) begin
        check("stall_data_held", int'(ifc.out_data), int'(held_data));
        check("stall_last_held", int'(ifc.out_last), int'(held_last));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_transfer: got data %0d with no expected entry (t=%0t)",
                   ifc.out_data, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("stream_data", int'(ifc.out_data), int'(e.data));
          check("stream_last", int'(ifc.out_last), int'(e.last));
        end
      end
      stall_prev = ifc.out_valid && !ifc.out_ready;
      held_data  = ifc.out_data;
      held_last  = ifc.out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    ifc.wr_en     = 1'b0;
    ifc.wr_addr   = '0;
    ifc.wr_data   = '0;
    ifc.cnt       = '0;
    ifc.start     = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_valid", int'(ifc.out_valid), 0);
    check("rst_last", int'(ifc.out_last), 0);
    check("rst_data", int'(ifc.out_data), 0);
    check("rst_done", int'(ifc.done), 0);
    rst = 1'b1;
    tick();

    // Full-depth stream: mem[i] = i+3, cnt 0 means 16 entries
    for (int i = 0; i < 16; i++) write_mem(i, i + 3);
    for (int i = 0; i < 16; i++) push(i + 3, i == 15);
    run_stream(0, 16, 0, 0, 1'b0, 0, 0);

    // Five-entry stream
    write_mem(0, 7); write_mem(1, 63); write_mem(2, 0); write_mem(3, 12); write_mem(4, 9);
    push(7, 0); push(63, 0); push(0, 0); push(12, 0); push(9, 1);
    run_stream(5, 5, 0, 0, 1'b0, 0, 0);

    // Backpressure 1,0,0 repeating: order preserved, data held while stalled
    write_mem(0, 21); write_mem(1, 5); write_mem(2, 50); write_mem(3, 1);
    write_mem(4, 33); write_mem(5, 8);
    push(21, 0); push(5, 0); push(50, 0); push(1, 0); push(33, 0); push(8, 1);
    run_stream(6, 6, 1, 0, 1'b0, 0, 0);

    // Write and start issued mid-stream are both ignored
    push(21, 0); push(5, 0); push(50, 1);
    run_stream(3, 3, 0, 1, 1'b0, 0, 0);
    push(21, 1);  // mem[0] still holds 21, not 42
    run_stream(1, 1, 0, 0, 1'b0, 0, 0);

    // Write to addr 0 in the same cycle as start is visible in the stream
    push(55, 0); push(5, 1);
    run_stream(2, 2, 0, 0, 1'b1, 0, 55);

    // Reset lands on the edge of the 3rd transfer of a 16-entry stream
    for (int i = 0; i < 16; i++) write_mem(i, i + 3);
    push(3, 0); push(4, 0);
    ifc.cnt   = 4'd0;
    ifc.start = 1'b1;
    tick();                 // start edge
    ifc.start = 1'b0;
    tick();                 // transfer 1
    tick();                 // transfer 2
    rst         = 1'b0;     // the next edge would be transfer 3
    ifc.start   = 1'b1;     // ignored under reset
    ifc.wr_en   = 1'b1;     // ignored under reset
    ifc.wr_addr = 4'd0;
    ifc.wr_data = 6'd33;
    tick();
    ifc.start = 1'b0;
    ifc.wr_en = 1'b0;
    check("abort_busy", int'(ifc.busy), 0);
    check("abort_valid", int'(ifc.out_valid), 0);
    check("abort_last", int'(ifc.out_last), 0);
    check("abort_data", int'(ifc.out_data), 0);
    check("abort_done", int'(ifc.done), 0);
    check("abort_transfers_seen", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_done", int'(ifc.done), 0);
    end
    check("abort_idle", int'(ifc.busy), 0);

    // Memory was cleared by reset, so the stream emits zeros
    push(0, 0); push(0, 0); push(0, 0); push(0, 1);
    run_stream(4, 4, 0, 0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
